// File: rtl/knob_table_pkg.sv
// knob_table_pkg: op codes, FSM states and response flags shared by knob_table.
// The scan states exist only when KNOB_TABLE_ITER_EN is defined.
package knob_table_pkg;

   typedef enum logic [2:0] {
      OP_GET    = 3'd0,
      OP_SET    = 3'd1,
      OP_EXISTS = 3'd2,
      OP_ITER   = 3'd3,
      OP_DEL    = 3'd4
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_RESP
`ifdef KNOB_TABLE_ITER_EN
      ,
      ST_SCAN,
      ST_SCAN_RESP
`endif
   } state_e;

   typedef struct packed {
      logic hit;
      logic last;
   } rsp_flags_t;

   localparam rsp_flags_t RSP_MISS_LAST = '{hit: 1'b0, last: 1'b1};
   localparam rsp_flags_t RSP_HIT_LAST  = '{hit: 1'b1, last: 1'b1};

endpackage

// File: rtl/knob_table_match.sv
// knob_match: per-entry masked key compare plus lowest-index match and free-slot encoders.
module knob_match #(
   parameter int NUM_KNOBS = 16,
   parameter int KEY_W     = 16,
   parameter int IDX_W     = $clog2(NUM_KNOBS)
) (
   input  logic [NUM_KNOBS-1:0]            valid,
   input  logic [NUM_KNOBS-1:0][KEY_W-1:0] keys,
   input  logic [KEY_W-1:0]                key,
   input  logic [KEY_W-1:0]                mask,
   output logic [NUM_KNOBS-1:0]            match_vec,
   output logic                            hit,
   output logic [IDX_W-1:0]                hit_idx,
   output logic                            free_any,
   output logic [IDX_W-1:0]                free_idx
);

   always_comb begin
      for (int unsigned i = 0; i < NUM_KNOBS; i++) begin
         match_vec[i] = valid[i] && ((keys[i] & mask) == (key & mask));
      end
   end

   // First set bit wins in both encoders, giving lowest-index priority.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      free_any = 1'b0;
      free_idx = '0;
      for (int unsigned i = 0; i < NUM_KNOBS; i++) begin
         if (match_vec[i] && !hit) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
         if (!valid[i] && !free_any) begin
            free_any = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/knob_table.sv
// Keyed value store with GET/SET/EXISTS/DEL and a request/response handshake.
// The masked ITER scan is optional; when it is not built, ITER is an illegal op.
module knob_table
   import knob_table_pkg::*;
#(
   parameter int NUM_KNOBS = 16,
   parameter int KEY_W     = 16,
   parameter int VAL_W     = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [2:0]                     req_op,
   input  logic [KEY_W-1:0]               req_key,
   input  logic [KEY_W-1:0]               req_mask,
   input  logic [VAL_W-1:0]               req_wdata,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic                           rsp_hit,
   output logic [VAL_W-1:0]               rsp_data,
   output logic [KEY_W-1:0]               rsp_key,
   output logic                           rsp_last,
   output logic [$clog2(NUM_KNOBS+1)-1:0] count,
   output logic                           full
);

   localparam int CNT_W = $clog2(NUM_KNOBS+1);
   localparam int IDX_W = $clog2(NUM_KNOBS);

   state_e                          state_q, state_d;
   logic                            alive_q, alive_d;
   logic [2:0]                      req_op_q, req_op_d;
   logic [KEY_W-1:0]                req_key_q, req_key_d;
   logic [VAL_W-1:0]                req_wdata_q, req_wdata_d;
   logic [NUM_KNOBS-1:0]            tbl_vld_q, tbl_vld_d;
   logic [NUM_KNOBS-1:0][KEY_W-1:0] tbl_key_q, tbl_key_d;
   logic [NUM_KNOBS-1:0][VAL_W-1:0] tbl_val_q, tbl_val_d;
   logic [CNT_W-1:0]                count_q, count_d;
   rsp_flags_t                      rsp_flg_q, rsp_flg_d;
   logic [VAL_W-1:0]                rsp_data_q, rsp_data_d;
   logic [KEY_W-1:0]                rsp_key_q, rsp_key_d;

   logic [KEY_W-1:0]                cmp_mask;
   logic [NUM_KNOBS-1:0]            match_vec;
   logic                            m_hit;
   logic [IDX_W-1:0]                m_hit_idx;
   logic                            m_free_any;
   logic [IDX_W-1:0]                m_free_idx;
   logic                            full_w;

`ifdef KNOB_TABLE_ITER_EN
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KNOBS-1);

   logic [KEY_W-1:0] req_mask_q, req_mask_d;
   logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
   logic             more_above;

   assign cmp_mask = (req_op_q == OP_ITER) ? req_mask_q : '1;

   // A match is the final one when nothing above the scan pointer matches.
   always_comb begin
      more_above = 1'b0;
      for (int unsigned i = 0; i < NUM_KNOBS; i++) begin
         if ((i > 32'(scan_idx_q)) && match_vec[i]) more_above = 1'b1;
      end
   end
`else
   logic unused_iter;

   assign cmp_mask    = '1;
   assign unused_iter = ^{req_mask, match_vec, m_free_any};
`endif

   knob_match #(
      .NUM_KNOBS (NUM_KNOBS),
      .KEY_W     (KEY_W),
      .IDX_W     (IDX_W)
   ) u_match (
      .valid     (tbl_vld_q),
      .keys      (tbl_key_q),
      .key       (req_key_q),
      .mask      (cmp_mask),
      .match_vec (match_vec),
      .hit       (m_hit),
      .hit_idx   (m_hit_idx),
      .free_any  (m_free_any),
      .free_idx  (m_free_idx)
   );

   assign full_w    = (count_q == CNT_W'(NUM_KNOBS));
   assign full      = full_w;
   assign count     = count_q;
   assign req_ready = alive_q && (state_q == ST_IDLE);
   assign rsp_hit   = rsp_flg_q.hit;
   assign rsp_last  = rsp_flg_q.last;
   assign rsp_data  = rsp_data_q;
   assign rsp_key   = rsp_key_q;
`ifdef KNOB_TABLE_ITER_EN
   assign rsp_valid = (state_q == ST_RESP) || (state_q == ST_SCAN_RESP);
`else
   assign rsp_valid = (state_q == ST_RESP);
`endif

   always_comb begin
      state_d     = state_q;
      alive_d     = 1'b1;
      req_op_d    = req_op_q;
      req_key_d   = req_key_q;
      req_wdata_d = req_wdata_q;
      tbl_vld_d   = tbl_vld_q;
      tbl_key_d   = tbl_key_q;
      tbl_val_d   = tbl_val_q;
      count_d     = count_q;
      rsp_flg_d   = rsp_flg_q;
      rsp_data_d  = rsp_data_q;
      rsp_key_d   = rsp_key_q;
`ifdef KNOB_TABLE_ITER_EN
      req_mask_d  = req_mask_q;
      scan_idx_d  = scan_idx_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               req_op_d    = req_op;
               req_key_d   = req_key;
               req_wdata_d = req_wdata;
`ifdef KNOB_TABLE_ITER_EN
               req_mask_d  = req_mask;
`endif
               state_d     = ST_LOOKUP;
            end
         end

         ST_LOOKUP: begin
            state_d    = ST_RESP;
            rsp_flg_d  = RSP_MISS_LAST;
            rsp_data_d = '0;
            rsp_key_d  = req_key_q;
            case (req_op_q)
               OP_GET: begin
                  rsp_flg_d.hit = m_hit;
                  rsp_data_d    = m_hit ? tbl_val_q[m_hit_idx] : req_wdata_q;
               end
               OP_SET: begin
                  if (m_hit) begin
                     tbl_val_d[m_hit_idx] = req_wdata_q;
                     rsp_flg_d            = RSP_HIT_LAST;
                  end else if (!full_w) begin
                     tbl_vld_d[m_free_idx] = 1'b1;
                     tbl_key_d[m_free_idx] = req_key_q;
                     tbl_val_d[m_free_idx] = req_wdata_q;
                     count_d               = count_q + CNT_W'(1);
                     rsp_flg_d             = RSP_HIT_LAST;
                  end
               end
               OP_EXISTS: rsp_flg_d.hit = m_hit;
               OP_DEL: begin
                  if (m_hit) begin
                     tbl_vld_d[m_hit_idx] = 1'b0;
                     count_d              = count_q - CNT_W'(1);
                     rsp_flg_d            = RSP_HIT_LAST;
                  end
               end
`ifdef KNOB_TABLE_ITER_EN
               OP_ITER: begin
                  state_d    = ST_SCAN;
                  scan_idx_d = '0;
               end
`endif
               default: ;
            endcase
         end

         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end

`ifdef KNOB_TABLE_ITER_EN
         ST_SCAN: begin
            if (match_vec[scan_idx_q]) begin
               state_d        = ST_SCAN_RESP;
               rsp_flg_d.hit  = 1'b1;
               rsp_flg_d.last = !more_above;
               rsp_data_d     = tbl_val_q[scan_idx_q];
               rsp_key_d      = tbl_key_q[scan_idx_q];
            end else if (scan_idx_q == LAST_IDX) begin
               // Reaching the end without a match means the scan found nothing.
               state_d    = ST_SCAN_RESP;
               rsp_flg_d  = RSP_MISS_LAST;
               rsp_data_d = '0;
               rsp_key_d  = req_key_q;
            end else begin
               scan_idx_d = scan_idx_q + IDX_W'(1);
            end
         end

         ST_SCAN_RESP: begin
            if (rsp_ready) begin
               if (rsp_flg_q.last) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d    = ST_SCAN;
                  scan_idx_d = scan_idx_q + IDX_W'(1);
               end
            end
         end
`endif

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         alive_q     <= 1'b0;
         req_op_q    <= '0;
         req_key_q   <= '0;
         req_wdata_q <= '0;
         tbl_vld_q   <= '0;
         tbl_key_q   <= '0;
         tbl_val_q   <= '0;
         count_q     <= '0;
         rsp_flg_q   <= '0;
         rsp_data_q  <= '0;
         rsp_key_q   <= '0;
`ifdef KNOB_TABLE_ITER_EN
         req_mask_q  <= '0;
         scan_idx_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         alive_q     <= alive_d;
         req_op_q    <= req_op_d;
         req_key_q   <= req_key_d;
         req_wdata_q <= req_wdata_d;
         tbl_vld_q   <= tbl_vld_d;
         tbl_key_q   <= tbl_key_d;
         tbl_val_q   <= tbl_val_d;
         count_q     <= count_d;
         rsp_flg_q   <= rsp_flg_d;
         rsp_data_q  <= rsp_data_d;
         rsp_key_q   <= rsp_key_d;
`ifdef KNOB_TABLE_ITER_EN
         req_mask_q  <= req_mask_d;
         scan_idx_q  <= scan_idx_d;
`endif
      end
   end

endmodule

// File: tb/tb_knob_table.sv
// tb_knob_table: randomized and directed checks of knob_table against a slot-array reference model.
// Follows KNOB_TABLE_ITER_EN the same way as the design.
module tb_knob_table;

   localparam int N  = 16;
   localparam int KW = 16;
   localparam int VW = 64;
   localparam int CW = $clog2(N+1);
`ifdef KNOB_TABLE_ITER_EN
   localparam bit ITER_EN = 1'b1;
`else
   localparam bit ITER_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [2:0]    req_op;
   logic [KW-1:0] req_key;
   logic [KW-1:0] req_mask;
   logic [VW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic          rsp_hit;
   logic [VW-1:0] rsp_data;
   logic [KW-1:0] rsp_key;
   logic          rsp_last;
   logic [CW-1:0] count;
   logic          full;

   always #5 clk = ~clk;

   knob_table #(
      .NUM_KNOBS (N),
      .KEY_W     (KW),
      .VAL_W     (VW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_key   (req_key),
      .req_mask  (req_mask),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_hit   (rsp_hit),
      .rsp_data  (rsp_data),
      .rsp_key   (rsp_key),
      .rsp_last  (rsp_last),
      .count     (count),
      .full      (full)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: slots in index order; SET allocates the lowest empty slot.
   logic          m_vld [N];
   logic [KW-1:0] m_key [N];
   logic [VW-1:0] m_val [N];
   int            m_cnt;

   typedef struct {
      logic          hit;
      logic [VW-1:0] data;
      logic [KW-1:0] key;
      logic          last;
      logic          chk_key;
   } exp_t;

   exp_t exp_q[$];

   function automatic void model_clear();
      for (int i = 0; i < N; i++) begin
         m_vld[i] = 1'b0;
         m_key[i] = '0;
         m_val[i] = '0;
      end
      m_cnt = 0;
   endfunction

   function automatic int find(input logic [KW-1:0] k);
      for (int i = 0; i < N; i++) if (m_vld[i] && m_key[i] == k) return i;
      return -1;
   endfunction

   function automatic void model(input logic [2:0] op, input logic [KW-1:0] key,
                                 input logic [KW-1:0] mask, input logic [VW-1:0] wdata);
      exp_t e;
      int   idx;
      int   hits[$];
      e   = '{hit: 1'b0, data: '0, key: key, last: 1'b1, chk_key: 1'b0};
      idx = find(key);
      if (op == 3'd3 && ITER_EN) begin
         for (int i = 0; i < N; i++)
            if (m_vld[i] && ((m_key[i] & mask) == (key & mask))) hits.push_back(i);
         if (hits.size() == 0) exp_q.push_back(e);
         for (int j = 0; j < hits.size(); j++)
            exp_q.push_back('{hit: 1'b1, data: m_val[hits[j]], key: m_key[hits[j]],
                              last: (j == hits.size() - 1), chk_key: 1'b1});
         return;
      end
      case (op)
         3'd0: begin
            e.hit  = (idx >= 0);
            e.data = (idx >= 0) ? m_val[idx] : wdata;
         end
         3'd1: begin
            if (idx >= 0) begin
               m_val[idx] = wdata;
               e.hit      = 1'b1;
            end else if (m_cnt < N) begin
               for (int i = 0; i < N; i++) begin
                  if (!m_vld[i]) begin
                     m_vld[i] = 1'b1;
                     m_key[i] = key;
                     m_val[i] = wdata;
                     break;
                  end
               end
               m_cnt++;
               e.hit = 1'b1;
            end
         end
         3'd2: e.hit = (idx >= 0);
         3'd4: begin
            if (idx >= 0) begin
               m_vld[idx] = 1'b0;
               m_cnt--;
               e.hit = 1'b1;
            end
         end
         default: ;
      endcase
      exp_q.push_back(e);
   endfunction

   task automatic issue(input logic [2:0] op, input logic [KW-1:0] key, input logic [KW-1:0] mask,
                        input logic [VW-1:0] wdata, output bit ok);
      int w = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_key   = key;
      req_mask  = mask;
      req_wdata = wdata;
      while (!req_ready && w < 64) begin
         @(negedge clk);
         w++;
      end
      ok = req_ready;
      if (!ok) begin
         check("req_ready_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic collect(input exp_t e, input int hold, input int exp_wait, output bit ok);
      int w = 0;
      logic [VW+KW+2:0] snap;
      @(negedge clk);
      w = 1;
      while (!rsp_valid && w < 64) begin
         @(negedge clk);
         w++;
      end
      ok = rsp_valid;
      if (!ok) begin
         check("rsp_timeout", 0, 1);
         return;
      end
      if (exp_wait > 0) check("rsp_latency", VW'(w), VW'(exp_wait));
      snap = {rsp_hit, rsp_last, rsp_data, rsp_key, rsp_valid};
      for (int j = 0; j < hold; j++) begin
         @(negedge clk);
         check("rsp_stable", VW'({rsp_hit, rsp_last, rsp_data, rsp_key, rsp_valid} != snap), 0);
      end
      check("rsp_hit", rsp_hit, e.hit);
      check("rsp_data", rsp_data, e.data);
      check("rsp_last", rsp_last, e.last);
      if (e.chk_key) check("rsp_key", rsp_key, e.key);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   task automatic txn(input logic [2:0] op, input logic [KW-1:0] key, input logic [KW-1:0] mask,
                      input logic [VW-1:0] wdata, input int hold);
      bit   ok;
      exp_t e;
      int   exp_wait;
      exp_q.delete();
      model(op, key, mask, wdata);
      exp_wait = (op == 3'd3 && ITER_EN) ? 0 : 1;
      issue(op, key, mask, wdata, ok);
      if (!ok) return;
      @(negedge clk);
      check("lookup_no_rsp", rsp_valid, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         collect(e, hold, exp_wait, ok);
         exp_wait = 0;
         if (!ok) begin
            exp_q.delete();
            return;
         end
      end
      check("count", VW'(count), VW'(m_cnt));
      check("full", full, (m_cnt == N));
   endtask

   task automatic reset_release();
      @(negedge clk);
      rst = 1'b0;
      #1 check("ready_low_at_release", req_ready, 0);
      @(posedge clk);
      #1 check("ready_after_release", req_ready, 1);
   endtask

   task automatic reset_values(input string tag);
      check({tag, "_rsp_valid"}, rsp_valid, 0);
      check({tag, "_rsp_hit"}, rsp_hit, 0);
      check({tag, "_rsp_data"}, rsp_data, 0);
      check({tag, "_rsp_key"}, rsp_key, 0);
      check({tag, "_rsp_last"}, rsp_last, 0);
      check({tag, "_req_ready"}, req_ready, 0);
      check({tag, "_count"}, VW'(count), 0);
      check({tag, "_full"}, full, 0);
   endtask

   task automatic reset_mid_response();
      bit ok;
      int w = 0;
      txn(3'd1, 16'h0300, '0, 64'h11, 0);
      txn(3'd1, 16'h0301, '0, 64'h22, 0);
      if (ITER_EN) issue(3'd3, 16'h0300, 16'hFF00, '0, ok);
      else         issue(3'd0, 16'h0300, '0, 64'h5, ok);
      if (!ok) return;
      while (!rsp_valid && w < 64) begin
         @(negedge clk);
         w++;
      end
      check("pre_reset_rsp_valid", rsp_valid, 1);
      rst = 1'b1;
      #1 reset_values("midrst");
      model_clear();
      @(negedge clk);
      check("midrst_held_rsp_valid", rsp_valid, 0);
      reset_release();
      repeat (3) begin
         @(negedge clk);
         check("post_reset_quiet", rsp_valid, 0);
      end
      txn(3'd0, 16'h0300, '0, 64'h77, 0);
      txn(3'd0, 16'h0301, '0, 64'h78, 0);
   endtask

   initial begin
      logic [KW-1:0] rk;
      logic [KW-1:0] rm;
      int            r;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_op    = '0;
      req_key   = '0;
      req_mask  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      reset_values("reset");
      reset_release();

      txn(3'd0, 16'h0022, '0, 64'hAB, 0);
      txn(3'd1, 16'h0010, '0, 64'd5, 0);
      txn(3'd0, 16'h0010, '0, 64'd9, 0);
      txn(3'd2, 16'h0010, '0, 64'hFF, 1);
      txn(3'd2, 16'h0011, '0, 64'hFF, 0);
      txn(3'd3, 16'h0010, 16'hFFFF, '0, 0);
      for (int op = 5; op < 8; op++) txn(3'(op), 16'h0010, '0, 64'h1, 0);
      txn(3'd4, 16'h0010, '0, '0, 0);
      txn(3'd4, 16'h0010, '0, '0, 0);
      txn(3'd3, 16'h0010, 16'h0000, '0, 0);

      for (int i = 0; i < N; i++) txn(3'd1, KW'(16'h1000 + i), '0, VW'(64'hA000 + i), 0);
      txn(3'd1, 16'h2000, '0, 64'hBEEF, 0);
      txn(3'd4, 16'h1005, '0, '0, 0);
      txn(3'd1, 16'h2000, '0, 64'hBEEF, 0);
      txn(3'd3, 16'h0000, 16'h0000, '0, 0);
      for (int i = 0; i < N; i++) txn(3'd4, KW'(16'h1000 + i), '0, '0, 0);
      txn(3'd4, 16'h2000, '0, '0, 0);

      txn(3'd1, 16'h0100, '0, 64'h100, 0);
      txn(3'd1, 16'h01FF, '0, 64'h1FF, 0);
      txn(3'd1, 16'h0200, '0, 64'h200, 0);
      txn(3'd3, 16'h0100, 16'h0F00, '0, 3);
      txn(3'd3, 16'h0500, 16'h0F00, '0, 1);

      for (int n = 0; n < 250; n++) begin
         rk = KW'($urandom_range(0, 23)) | 16'h0A00;
         case ($urandom_range(0, 3))
            0:       rm = 16'h0000;
            1:       rm = 16'hFFFF;
            2:       rm = 16'h000F;
            default: rm = KW'($urandom);
         endcase
         r = $urandom_range(0, 9);
         if (r <= 2)      txn(3'd1, rk, rm, {$urandom, $urandom}, $urandom_range(0, 3));
         else if (r <= 4) txn(3'd0, rk, rm, {$urandom, $urandom}, $urandom_range(0, 3));
         else if (r == 5) txn(3'd2, rk, rm, {$urandom, $urandom}, $urandom_range(0, 3));
         else if (r == 6) txn(3'd3, rk, rm, {$urandom, $urandom}, $urandom_range(0, 2));
         else if (r <= 8) txn(3'd4, rk, rm, {$urandom, $urandom}, $urandom_range(0, 3));
         else             txn(3'($urandom_range(5, 7)), rk, rm, {$urandom, $urandom}, 0);
      end

      reset_mid_response();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
